gate_tt_checker: RTL and testbench

GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

---
 rtl/gate_tt_checker_pkg.sv | 20 ++
 rtl/settle_timer.sv | 31 +++
 rtl/gate_tt_checker.sv | 109 ++++++++++
 tb/tb_gate_tt_checker.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/gate_tt_checker_pkg.sv
// Shared types and truth-table constants for the 2-input gate truth-table checker.
package gate_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Truth tables indexed by {A,B}
   localparam logic [3:0] NOR_TT  = 4'b0001;
   localparam logic [3:0] OR_TT   = 4'b1110;
   localparam logic [3:0] AND_TT  = 4'b1000;
   localparam logic [3:0] NAND_TT = 4'b0111;

   // Wide enough for SETTLE_CYCLES up to 15
   localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/settle_timer.sv
// Settle counter: clear has priority over enable; tc_o flags the last settle cycle.
module settle_timer
   import gate_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SETTLE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/gate_tt_checker.sv
// Walks {A,B} through 00..11, lets the attached gate settle, and compares Y with
// EXPECT_TT, accumulating a mismatch count and per-vector fail mask.
module gate_tt_checker
   import gate_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [3:0]  EXPECT_TT     = NOR_TT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       gate_a,
   output logic       gate_b,
   input  logic       gate_y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_cnt,
   output logic [3:0] fail_vec
);

   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [2:0] err_q, err_d;
   logic [3:0] fail_q, fail_d;
   logic       pass_q, pass_d;
   logic       tc;
   logic       mismatch;

   // Y is a combinational function of our own flops, so it is sampled directly
   assign mismatch = (gate_y != EXPECT_TT[idx_q]);

   settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (state_q != ST_SETTLE),
      .en_i  (state_q == ST_SETTLE),
      .tc_o  (tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_SETTLE;
         ST_SETTLE: if (tc)    state_d = ST_SAMPLE;
         ST_SAMPLE: state_d = (idx_q == 2'd3) ? ST_DONE : ST_SETTLE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
      done = (state_q == ST_DONE);
   end

   always_comb begin
      idx_d  = idx_q;
      err_d  = err_q;
      fail_d = fail_q;
      pass_d = pass_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               idx_d  = 2'd0;
               err_d  = 3'd0;
               fail_d = 4'd0;
               pass_d = 1'b0;
            end
         end
         ST_SAMPLE: begin
            if (mismatch) begin
               fail_d[idx_q] = 1'b1;
               err_d         = err_q + 3'd1;
            end
            if (idx_q != 2'd3) idx_d  = idx_q + 2'd1;
            else               pass_d = !mismatch && (err_q == 3'd0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= 2'd0;
         err_q  <= 3'd0;
         fail_q <= 4'd0;
         pass_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         err_q  <= err_d;
         fail_q <= fail_d;
         pass_q <= pass_d;
      end
   end

   // The driven vector always equals idx, and idx holds after the pass
   assign gate_a   = idx_q[1];
   assign gate_b   = idx_q[0];
   assign err_cnt  = err_q;
   assign fail_vec = fail_q;
   assign pass     = pass_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench: table of attached-gate truth tables plus hand-written
// sequences for held start, mid-pass reset and SETTLE_CYCLES=1.
module tb_gate_tt_checker;

   logic       clk, rst_n;
   logic       start, gate_a, gate_b, gate_y, busy, done, pass;
   logic [2:0] err_cnt;
   logic [3:0] fail_vec;
   logic [3:0] tt_q;

   logic       start2, ga2, gb2, gy2, busy2, done2, pass2;
   logic [2:0] err2;
   logic [3:0] fail2;

   int n_cmp, n_bad;

   assign gate_y = tt_q[{gate_a, gate_b}];
   assign gy2    = ~(ga2 | gb2);

   gate_tt_checker #(.SETTLE_CYCLES(2), .EXPECT_TT(4'b0001)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .gate_a(gate_a), .gate_b(gate_b),
      .gate_y(gate_y), .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .fail_vec(fail_vec)
   );

   gate_tt_checker #(.SETTLE_CYCLES(1), .EXPECT_TT(4'b0001)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start2), .gate_a(ga2), .gate_b(gb2),
      .gate_y(gy2), .busy(busy2), .done(done2), .pass(pass2),
      .err_cnt(err2), .fail_vec(fail2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   typedef struct {
      string      nm;
      logic [3:0] tt;
      int         err;
      logic [3:0] fail;
      logic       pass;
   } vec_t;

   // One full pass on the SETTLE_CYCLES=2 instance with the given gate attached
   task automatic run_pass(input vec_t v);
      int lat;
      bit seq_ok;
      tt_q = v.tt;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      lat = -1; seq_ok = 1'b1;
      for (int n = 0; n < 40; n++) begin
         if (done) begin lat = n; break; end
         if ({gate_a, gate_b} != 2'(n / 3) || !busy) seq_ok = 1'b0;
         @(posedge clk); #1;
      end
      check({v.nm, " latency"}, lat, 12);
      check({v.nm, " vec_seq"}, int'(seq_ok), 1);
      check({v.nm, " err_cnt"}, int'(err_cnt), v.err);
      check({v.nm, " fail_vec"}, int'(fail_vec), int'(v.fail));
      check({v.nm, " pass"}, int'(pass), int'(v.pass));
      @(posedge clk); #1;
      check({v.nm, " hold"}, int'({done, busy, pass, err_cnt, fail_vec, gate_a, gate_b}),
            int'({1'b0, 1'b0, v.pass, 3'(v.err), v.fail, 2'b11}));
   endtask

   vec_t tbl[6];
   logic done_a[30], busy_a[30];
   logic [2:0] err_a[30];

   initial begin
      int ndone, lat;
      bit seq_ok, quiet;
      n_cmp = 0; n_bad = 0;
      tt_q = 4'b0001; start = 1'b0; start2 = 1'b0; rst_n = 1'b0;

      tbl[0] = '{"nor",    4'b0001, 0, 4'b0000, 1'b1};
      tbl[1] = '{"stuck0", 4'b0000, 1, 4'b0001, 1'b0};
      tbl[2] = '{"or",     4'b1110, 4, 4'b1111, 1'b0};
      tbl[3] = '{"and",    4'b1000, 2, 4'b1001, 1'b0};
      tbl[4] = '{"nand",   4'b0111, 2, 4'b0110, 1'b0};
      tbl[5] = '{"stuck1", 4'b1111, 3, 4'b1110, 1'b0};

      #2;
      check("reset_outs", int'({gate_a, gate_b, busy, done, pass, err_cnt, fail_vec}), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_after_reset", int'({busy, done}), 0);

      foreach (tbl[i]) run_pass(tbl[i]);

      // start held high: passes back to back, err cleared on re-acceptance
      tt_q = 4'b1110;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      ndone = 0;
      for (int n = 0; n < 30; n++) begin
         done_a[n] = done; busy_a[n] = busy; err_a[n] = err_cnt;
         if (n <= 13 && done) ndone++;
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("held done_count", ndone, 1);
      check("held done_at12", int'(done_a[12]), 1);
      check("held err_in_idle", int'(err_a[13]), 4);
      check("held idle_gap", int'(busy_a[13]), 0);
      check("held restart_busy", int'(busy_a[14]), 1);
      check("held err_cleared", int'(err_a[14]), 0);
      check("held done2_at26", int'(done_a[26]), 1);
      check("held third_start", int'({busy_a[27], busy_a[28]}), 1);
      quiet = 1'b0;
      for (int n = 0; n < 60; n++) begin
         if (!busy && !done) begin quiet = 1'b1; break; end
         @(posedge clk); #1;
      end
      check("held drains", int'(quiet), 1);

      // SETTLE_CYCLES=1 instance
      @(negedge clk); start2 = 1'b1;
      @(posedge clk); #1; start2 = 1'b0;
      lat = -1; seq_ok = 1'b1;
      for (int n = 0; n < 30; n++) begin
         if (done2) begin lat = n; break; end
         if ({ga2, gb2} != 2'(n / 2) || !busy2) seq_ok = 1'b0;
         @(posedge clk); #1;
      end
      check("sc1 latency", lat, 8);
      check("sc1 vec_seq", int'(seq_ok), 1);
      check("sc1 result", int'({pass2, err2, fail2}), int'({1'b1, 3'd0, 4'd0}));

      // reset during SETTLE of vector 2
      tt_q = 4'b0001;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      check("mid vec2", int'({gate_a, gate_b, busy}), int'(3'b101));
      rst_n = 1'b0;
      #1;
      check("mid reset_outs", int'({gate_a, gate_b, busy, done, pass, err_cnt, fail_vec}), 0);
      @(negedge clk); rst_n = 1'b1;
      quiet = 1'b1;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk); #1;
         if (done || busy) quiet = 1'b0;
      end
      check("mid no_done", int'(quiet), 1);

      run_pass(tbl[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
